// File: rtl/load_nanofs_file.sv
// load_nanofs_file: loads one file from a nanofs volume over a block-level
// SPI/SD reader.
//
// Load sequence:
// - The header block at start_reg gives a 32-bit little-endian file size
//   in bytes 0-3 and a checksum in byte 4.
// - The payload follows in consecutive blocks from start_reg+1.
// - Each payload byte is offered on data_out/byte_addr with data_valid.
//
// Handshake: data_valid is high only in EMIT. data_out and byte_addr hold
// steady until data_ready is seen high on a clock edge. That edge is the
// transfer.
//
// Optional feature: define NANOFS_CHECKSUM_EN to XOR every emitted byte and
// compare the result with header byte 4 at the end of the load.
//
// debug_leds exposes the low 4 bits of the FSM state.
module load_nanofs_file #(
    parameter logic [31:0] MAX_BYTES   = 32'h0010_0000,
    parameter int unsigned BLOCK_BYTES = 512
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [31:0] start_reg,
    output logic        success,
    output logic        err_signal,
    output logic [31:0] file_size,
    output logic [7:0]  data_out,
    output logic        data_valid,
    input  logic        data_ready,
    output logic [31:0] byte_addr,
    output logic        spi_r_block,
    output logic        spi_r_byte,
    input  logic        spi_busy,
    input  logic        spi_err,
    output logic [31:0] spi_block_addr,
    input  logic [7:0]  spi_data_out,
    output logic [3:0]  debug_leds
);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        HDR_OPEN  = 4'd1,
        HDR_WAIT  = 4'd2,
        HDR_BYTE  = 4'd3,
        HDR_BWAIT = 4'd4,
        CLOSE     = 4'd5,
        DAT_OPEN  = 4'd6,
        DAT_WAIT  = 4'd7,
        DAT_BYTE  = 4'd8,
        DAT_BWAIT = 4'd9,
        EMIT      = 4'd10,
        CHECK     = 4'd11,
        SUCCESS   = 4'd12,
        ERROR     = 4'd13
    } state_t;

    state_t      state, state_next;
    logic [2:0]  hdr_cnt;   // header bytes consumed so far (0..5)
    logic [31:0] blk_cnt;   // bytes read from the currently open data block
    logic        in_data;   // header done; block address follows byte_addr
    logic        byte_ok;   // BWAIT sample condition: reader idle, no error
    logic        xfer;      // payload byte accepted by the consumer

`ifdef NANOFS_CHECKSUM_EN
    logic [7:0]  cks_exp;
    logic [7:0]  cks_acc;
`endif

    assign byte_ok = !spi_err && !spi_busy;
    assign xfer    = (state == EMIT) && data_ready;

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // Next-state logic; spi_err is checked before spi_busy everywhere
    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (start) state_next = HDR_OPEN;
            HDR_OPEN:  if (!spi_busy) state_next = HDR_WAIT;
            HDR_WAIT:  if (spi_err) state_next = ERROR;
                       else if (!spi_busy) state_next = HDR_BYTE;
            HDR_BYTE:  state_next = HDR_BWAIT;
            HDR_BWAIT: if (spi_err) state_next = ERROR;
                       else if (!spi_busy) state_next = (hdr_cnt == 3'd4) ? CLOSE : HDR_BYTE;
            CLOSE: begin
                if (!in_data) begin
                    if (file_size > MAX_BYTES)  state_next = ERROR;
                    else if (file_size == '0)   state_next = CHECK;
                    else                        state_next = DAT_OPEN;
                end else if (byte_addr == file_size) begin
                    state_next = CHECK;
                end else begin
                    state_next = DAT_OPEN;
                end
            end
            DAT_OPEN:  if (!spi_busy) state_next = DAT_WAIT;
            DAT_WAIT:  if (spi_err) state_next = ERROR;
                       else if (!spi_busy) state_next = DAT_BYTE;
            DAT_BYTE:  state_next = DAT_BWAIT;
            DAT_BWAIT: if (spi_err) state_next = ERROR;
                       else if (!spi_busy) state_next = EMIT;
            EMIT: begin
                if (data_ready) begin
                    // The last byte also closes its block before CHECK
                    if (byte_addr + 32'd1 == file_size)       state_next = CLOSE;
                    else if (blk_cnt == 32'(BLOCK_BYTES))      state_next = CLOSE;
                    else                                       state_next = DAT_BYTE;
                end
            end
`ifdef NANOFS_CHECKSUM_EN
            CHECK:     state_next = (cks_acc == cks_exp) ? SUCCESS : ERROR;
`else
            CHECK:     state_next = SUCCESS;
`endif
            SUCCESS:   state_next = SUCCESS;
            ERROR:     state_next = ERROR;
            default:   state_next = ERROR;
        endcase
    end

    // Counters, header fields and the payload byte register
    always_ff @(posedge clk) begin
        if (reset) begin
            hdr_cnt   <= '0;
            blk_cnt   <= '0;
            in_data   <= 1'b0;
            file_size <= '0;
            data_out  <= '0;
            byte_addr <= '0;
        end else begin
            case (state)
                IDLE: begin
                    hdr_cnt   <= '0;
                    blk_cnt   <= '0;
                    byte_addr <= '0;
                    in_data   <= 1'b0;
                end
                HDR_BWAIT: if (byte_ok) begin
                    case (hdr_cnt)
                        3'd0:    file_size[7:0]   <= spi_data_out;
                        3'd1:    file_size[15:8]  <= spi_data_out;
                        3'd2:    file_size[23:16] <= spi_data_out;
                        3'd3:    file_size[31:24] <= spi_data_out;
                        default: ;
                    endcase
                    hdr_cnt <= hdr_cnt + 3'd1;
                end
                CLOSE: begin
                    blk_cnt <= '0;
                    in_data <= 1'b1;
                end
                DAT_BWAIT: if (byte_ok) begin
                    data_out <= spi_data_out;
                    blk_cnt  <= blk_cnt + 32'd1;
                end
                EMIT: if (data_ready) byte_addr <= byte_addr + 32'd1;
                default: ;
            endcase
        end
    end

`ifdef NANOFS_CHECKSUM_EN
    // Expected checksum from header byte 4 and running XOR of emitted bytes
    always_ff @(posedge clk) begin
        if (reset) begin
            cks_exp <= '0;
            cks_acc <= '0;
        end else begin
            if (state == IDLE) cks_acc <= '0;
            else if (xfer)     cks_acc <= cks_acc ^ data_out;
            if (state == HDR_BWAIT && byte_ok && hdr_cnt == 3'd4) cks_exp <= spi_data_out;
        end
    end
`endif

    // Moore outputs decoded from the state
    always_comb begin
        success     = (state == SUCCESS);
        err_signal  = (state == ERROR);
        data_valid  = (state == EMIT);
        spi_r_byte  = (state == HDR_BYTE) || (state == DAT_BYTE);
        spi_r_block = (state == HDR_WAIT) || (state == HDR_BYTE) || (state == HDR_BWAIT) ||
                      (state == DAT_WAIT) || (state == DAT_BYTE) || (state == DAT_BWAIT) ||
                      (state == EMIT);
        debug_leds  = state[3:0];
        spi_block_addr = in_data ? (start_reg + 32'd1 + (byte_addr / 32'(BLOCK_BYTES)))
                                 : start_reg;
    end

endmodule

// File: doc/load_nanofs_file.md
LOAD_NANOFS_FILE -- requirements
Module: load_nanofs_file

Interface
REQ-001 SHALL have parameter MAX_BYTES, default 32'h0010_0000, the largest accepted file size in bytes.
REQ-002 SHALL have parameter BLOCK_BYTES, default 512, the bytes per SD block.
REQ-003 SHALL have port clk, input, 1, the single clock.
REQ-004 SHALL have port reset, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port start, input, 1, the load request, sampled only in IDLE.
REQ-006 SHALL have port start_reg, input, 32, the header block address produced by the filesystem init stage.
REQ-007 SHALL have port success, output, 1, asserted when the load completed.
REQ-008 SHALL have port err_signal, output, 1, asserted when the load failed.
REQ-009 SHALL have port file_size, output, 32, the size latched from the header.
REQ-010 SHALL have port data_out, output, 8, the payload byte.
REQ-011 SHALL have port data_valid, output, 1, which qualifies data_out and byte_addr.
REQ-012 SHALL have port data_ready, input, 1, the consumer accept.
REQ-013 SHALL have port byte_addr, output, 32, the payload offset of data_out.
REQ-014 SHALL have SPI ports: spi_r_block out 1, spi_r_byte out 1, spi_busy in 1, spi_err in 1, spi_block_addr out 32, spi_data_out in 8.
REQ-015 SHALL have port debug_leds, output, 4, driven with the low 4 bits of the state encoding.

Function
REQ-016 SHALL implement the states IDLE, HDR_OPEN, HDR_WAIT, HDR_BYTE, HDR_BWAIT, CLOSE, DAT_OPEN, DAT_WAIT, DAT_BYTE, DAT_BWAIT, EMIT, CHECK, SUCCESS and ERROR.
REQ-017 SHALL, in IDLE, clear the byte counters and hold spi_block_addr at start_reg, and SHALL move to HDR_OPEN on start=1.
REQ-018 SHALL handle the block protocol as follows: OPEN waits for spi_busy=0, then raises spi_r_block. spi_r_block stays high through the WAIT, BYTE and BWAIT states. WAIT exits when spi_busy=0.
REQ-019 SHALL, in each BYTE state, pulse spi_r_byte for exactly 1 cycle; the BWAIT state then samples spi_data_out on the first cycle with spi_busy=0.
REQ-020 SHALL read header bytes 0-3 as file_size (little-endian) and byte 4 as the expected checksum; header bytes 5 onward are not read.
REQ-021 SHALL, after each block, go through CLOSE, which drops spi_r_block for at least 1 cycle before the next OPEN.
REQ-022 SHALL go from header CLOSE to ERROR if file_size > MAX_BYTES, and SHALL go to CHECK if file_size = 0.
REQ-023 SHALL read data blocks from addresses start_reg+1, +2, and so on; spi_block_addr = start_reg + 1 + (byte_addr / BLOCK_BYTES) in 32-bit wrap-around arithmetic.
REQ-024 SHALL, in EMIT, hold data_valid=1 with data_out and byte_addr stable until data_ready=1. On the transfer cycle byte_addr increments.
REQ-025 SHALL leave EMIT as follows: to CHECK when byte_addr+1 = file_size (the block is closed first), to CLOSE when the in-block counter reaches BLOCK_BYTES, and to DAT_BYTE otherwise.
REQ-026 SHALL keep the last block's unread bytes unread; the block is released by CLOSE.
REQ-027 SHALL go to ERROR if spi_err=1 in any WAIT or BWAIT state; spi_err takes priority over spi_busy=0 in the same cycle.
REQ-028 SHALL make SUCCESS and ERROR sticky until reset; start is ignored there, and all SPI requests and data_valid are 0.
REQ-029 SHALL keep data_valid=0 outside EMIT; data_ready outside EMIT is ignored.

Reset
REQ-030 SHALL, on reset=1 at a clk edge, go to IDLE from any state, including mid-block and mid-EMIT.
REQ-031 SHALL give these outputs the reset value 0: success, err_signal, data_valid, spi_r_block, spi_r_byte, byte_addr, file_size and data_out.

Configuration
REQ-032 SHALL, with NANOFS_CHECKSUM_EN defined, XOR every emitted payload byte into an 8-bit accumulator; CHECK goes to SUCCESS if the accumulator equals header byte 4, and to ERROR otherwise.
REQ-033 SHALL, without NANOFS_CHECKSUM_EN, not instantiate the accumulator; header byte 4 is still read but ignored, and CHECK always goes to SUCCESS.

Verification
REQ-034 SHALL cover this case: file_size=3, payload 11 22 33, checksum 00, data_ready=1 -> bytes at byte_addr 0,1,2 from block start_reg+1, then success=1.
REQ-035 SHALL cover this case: file_size=513 -> 512 bytes from start_reg+1, spi_r_block low for at least 1 cycle, then 1 byte from start_reg+2, then success=1.
REQ-036 SHALL cover this case: data_ready held 0 for 5 cycles in EMIT -> data_valid=1 and data_out and byte_addr unchanged, with no spi_r_byte pulse.
REQ-037 SHALL cover this case: spi_err=1 during DAT_BWAIT -> err_signal=1 sticky, spi_r_block=0, and start ignored until reset.
REQ-038 SHALL cover this case: file_size=MAX_BYTES+1 -> err_signal=1 with no data_valid; file_size=0 -> success=1 with no data_valid.
REQ-039 SHALL cover this case with NANOFS_CHECKSUM_EN: payload A5 5A with checksum FF gives success=1, and the same payload with checksum 00 gives err_signal=1.
